udma_tx_chan_resp: RTL and testbench
====================================

UDMA_TX_CHAN_RESP -- requirements
Module: udma_tx_chan_resp

Interface
REQ-001 SHALL use one clock, sys_clk_i; reset rstn_i SHALL be asynchronous and active-low.
REQ-002 SHALL have parameter L2_AWIDTH_NOAL, default 12: byte-address width.
REQ-003 SHALL have parameter TRANS_SIZE, default 16: transfer-size width.
REQ-004 SHALL have parameter MEM_AWIDTH, default 8: word-address width of the internal memory; L2_AWIDTH_NOAL >= MEM_AWIDTH+2.
REQ-005 sys_clk_i  in  1  clock.
REQ-006 rstn_i  in  1  asynchronous active-low reset.
REQ-007 cfg_startaddr_i  in  L2_AWIDTH_NOAL  start byte address.
REQ-008 cfg_size_i  in  TRANS_SIZE  transfer length in bytes.
REQ-009 cfg_continuous_i  in  1  reload the same transfer on completion.
REQ-010 cfg_en_i  in  1  single-cycle start pulse.
REQ-011 cfg_clr_i  in  1  single-cycle abort pulse.
REQ-012 cfg_en_o  out  1  transfer active.
REQ-013 cfg_pending_o  out  1  one queued transfer waiting.
REQ-014 cfg_curr_addr_o  out  L2_AWIDTH_NOAL  next byte address.
REQ-015 cfg_bytes_left_o  out  TRANS_SIZE  remaining bytes.
REQ-016 req_i  in  1  peripheral TX request.
REQ-017 gnt_o  out  1  grant, one-cycle pulse.
REQ-018 datasize_i  in  2  0=byte, 1=halfword, 2=word; sampled with req_i.
REQ-019 data_o  out  32  TX data, zero-extended.
REQ-020 valid_o  out  1  data_o valid.
REQ-021 ready_i  in  1  peripheral accepts data.
REQ-022 mem_we_i  in  1  memory preload write enable.
REQ-023 mem_waddr_i  in  MEM_AWIDTH  preload word address.
REQ-024 mem_wdata_i  in  32  preload data.

Function
REQ-025 FSM states: IDLE, WAIT_REQ, GRANT, DATA.
- IDLE -> WAIT_REQ on cfg_en_i: load curr_addr=cfg_startaddr_i, bytes_left=cfg_size_i, cfg_en_o=1.
- WAIT_REQ -> GRANT when req_i=1: gnt_o=1 for exactly one cycle; datasize_i is latched.
- GRANT -> DATA on the next cycle: valid_o=1. data_o is the memory word at curr_addr[MEM_AWIDTH+1:2], shifted right by 8*curr_addr[1:0] and masked to the latched datasize.
REQ-026 data_o and valid_o SHALL hold stable while valid_o=1 and ready_i=0.
- The beat completes on the cycle with valid_o&ready_i.
- On completion: curr_addr += 1/2/4 (by datasize), wrapping modulo 2^L2_AWIDTH_NOAL; bytes_left -= the same amount, saturating at 0.
REQ-027 On beat completion:
- If bytes_left reaches 0 and continuous=1, SHALL reload start/size and return to WAIT_REQ.
- Else if bytes_left reaches 0 and pending=1, SHALL load the queued transfer and clear pending.
- Else if bytes_left reaches 0, SHALL go to IDLE and drop cfg_en_o.
- Otherwise SHALL return to WAIT_REQ.
REQ-028 cfg_en_i while cfg_en_o=1 SHALL queue start/size/continuous and set cfg_pending_o. A second cfg_en_i while pending overwrites the queue.
REQ-029 cfg_clr_i SHALL force IDLE and clear cfg_en_o, cfg_pending_o, valid_o and gnt_o next cycle. cfg_clr_i wins over a simultaneous cfg_en_i.
REQ-030 cfg_en_i with cfg_size_i=0 SHALL be ignored.
REQ-031 req_i SHALL be ignored in IDLE; gnt_o never asserts while cfg_en_o=0.
REQ-032 Memory writes SHALL take effect the next cycle. A same-cycle write and read of one word returns the old data.
REQ-033 Minimum beat latency: req_i to gnt_o 1 cycle; gnt_o to valid_o 1 cycle.

Reset
REQ-034 rstn_i low SHALL immediately force IDLE. All outputs, curr_addr, bytes_left, pending and the queue SHALL be 0. Memory contents are not reset.
REQ-035 Reset mid-transfer SHALL abandon the beat with no further gnt_o or valid_o.

Configuration
REQ-036 With UDMA_TX_RESP_STALL_EN defined, SHALL add input stall_cycles_i (4 bits): gnt_o is delayed by stall_cycles_i cycles after req_i is seen in WAIT_REQ. Without the macro, the port is absent and the grant is delayed by 0 cycles.

Verification
REQ-037 Bench SHALL cover:
- Preload word0=0x44332211, start=0, size=4, three byte beats with ready_i=1 -> data_o 0x11, 0x22, 0x33; bytes_left 3, 2, 1.
- Start=2, size=2, halfword beat, ready_i low for 3 cycles -> data_o=0x4433 held for 4 cycles, then cfg_en_o=0.
- Continuous, size=4, word beats -> repeated 0x44332211, curr_addr reloaded to 0, cfg_en_o stays 1.
- cfg_en_i during active transfer -> cfg_pending_o=1; queued transfer starts after the last beat; pending clears.
- cfg_clr_i while valid_o=1 -> valid_o=0 and cfg_en_o=0 next cycle; no gnt_o on a later req_i.
- With UDMA_TX_RESP_STALL_EN and stall_cycles_i=3 -> gnt_o 4 cycles after req_i.

Source files
------------

// File: rtl/udma_tx_chan_resp.sv
`default_nettype none
// ============================================================================
// Module   : udma_tx_chan_resp
// Purpose  : Single-channel uDMA TX responder. It serves byte, halfword or
//            word beats to a peripheral from a small preloaded word memory.
//            One active transfer can be followed by one queued transfer, and
//            continuous mode restarts the same transfer when it completes.
// Ports    : sys_clk_i / rstn_i         clock, asynchronous active-low reset
//            cfg_*_i                    start address, size, continuous flag,
//                                       start pulse, abort pulse
//            cfg_*_o                    active, pending, next address,
//                                       bytes left
//            req_i/datasize_i/gnt_o     peripheral request / width / grant
//            data_o/valid_o/ready_i     TX data beat handshake
//            mem_we_i/waddr_i/wdata_i   memory preload port
//            stall_cycles_i             grant delay (only with macro below)
// Options  : UDMA_TX_RESP_STALL_EN adds stall_cycles_i, which delays gnt_o by
//            that many cycles after a request is seen.
// Revision : 1.0 - initial release
// ============================================================================
module udma_tx_chan_resp #(
    parameter int L2_AWIDTH_NOAL = 12,
    parameter int TRANS_SIZE     = 16,
    parameter int MEM_AWIDTH     = 8
) (
    input  logic                      sys_clk_i,
    input  logic                      rstn_i,
    input  logic [L2_AWIDTH_NOAL-1:0] cfg_startaddr_i,
    input  logic [TRANS_SIZE-1:0]     cfg_size_i,
    input  logic                      cfg_continuous_i,
    input  logic                      cfg_en_i,
    input  logic                      cfg_clr_i,
    output logic                      cfg_en_o,
    output logic                      cfg_pending_o,
    output logic [L2_AWIDTH_NOAL-1:0] cfg_curr_addr_o,
    output logic [TRANS_SIZE-1:0]     cfg_bytes_left_o,
    input  logic                      req_i,
    output logic                      gnt_o,
    input  logic [1:0]                datasize_i,
`ifdef UDMA_TX_RESP_STALL_EN
    input  logic [3:0]                stall_cycles_i,
`endif
    output logic [31:0]               data_o,
    output logic                      valid_o,
    input  logic                      ready_i,
    input  logic                      mem_we_i,
    input  logic [MEM_AWIDTH-1:0]     mem_waddr_i,
    input  logic [31:0]               mem_wdata_i
);

    localparam int       MEM_DEPTH   = 1 << MEM_AWIDTH;
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_REQ = 2'd1;
    localparam logic [1:0] ST_GRANT    = 2'd2;
    localparam logic [1:0] ST_DATA     = 2'd3;

    logic [1:0]                state_q,     state_d;
    logic [L2_AWIDTH_NOAL-1:0] curr_addr_q, curr_addr_d;
    logic [L2_AWIDTH_NOAL-1:0] start_q,     start_d;
    logic [L2_AWIDTH_NOAL-1:0] pend_addr_q, pend_addr_d;
    logic [TRANS_SIZE-1:0]     bytes_left_q, bytes_left_d;
    logic [TRANS_SIZE-1:0]     size_q,      size_d;
    logic [TRANS_SIZE-1:0]     pend_size_q, pend_size_d;
    logic                      cont_q,      cont_d;
    logic                      pend_cont_q, pend_cont_d;
    logic                      pending_q,   pending_d;
    logic [1:0]                dsize_q,     dsize_d;
    logic [31:0]               data_q,      data_d;
`ifdef UDMA_TX_RESP_STALL_EN
    logic                      req_seen_q,  req_seen_d;
    logic [3:0]                stall_cnt_q, stall_cnt_d;
`endif

    logic [31:0] mem_q [MEM_DEPTH];

    logic [2:0]                w_step;
    logic [L2_AWIDTH_NOAL-1:0] w_next_addr;
    logic [TRANS_SIZE-1:0]     w_step_ts;
    logic [TRANS_SIZE-1:0]     w_next_left;
    logic [31:0]               w_word;
    logic [31:0]               w_shift;
    logic [31:0]               w_rd_data;

    // Preload memory: no reset, write visible from the next cycle. Reads are
    // combinational from the array, so a same-cycle write returns old data.
    always_ff @(posedge sys_clk_i) begin
        if (mem_we_i) begin
            mem_q[mem_waddr_i] <= mem_wdata_i;
        end
    end

    // Beat size and address/length arithmetic (datasize 3 treated as word)
    always_comb begin
        case (dsize_q)
            2'd0:    w_step = 3'd1;
            2'd1:    w_step = 3'd2;
            default: w_step = 3'd4;
        endcase
        w_step_ts   = {{(TRANS_SIZE-3){1'b0}}, w_step};
        w_next_addr = curr_addr_q + {{(L2_AWIDTH_NOAL-3){1'b0}}, w_step};
        w_next_left = (bytes_left_q > w_step_ts) ? (bytes_left_q - w_step_ts)
                                                 : '0;
        w_word      = mem_q[curr_addr_q[MEM_AWIDTH+1:2]];
        w_shift     = w_word >> {curr_addr_q[1:0], 3'b000};
        case (dsize_q)
            2'd0:    w_rd_data = {24'h0, w_shift[7:0]};
            2'd1:    w_rd_data = {16'h0, w_shift[15:0]};
            default: w_rd_data = w_shift;
        endcase
    end

    // State register
    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= ST_IDLE;
            curr_addr_q  <= '0;
            start_q      <= '0;
            pend_addr_q  <= '0;
            bytes_left_q <= '0;
            size_q       <= '0;
            pend_size_q  <= '0;
            cont_q       <= 1'b0;
            pend_cont_q  <= 1'b0;
            pending_q    <= 1'b0;
            dsize_q      <= 2'd0;
            data_q       <= '0;
`ifdef UDMA_TX_RESP_STALL_EN
            req_seen_q   <= 1'b0;
            stall_cnt_q  <= 4'd0;
`endif
        end else begin
            state_q      <= state_d;
            curr_addr_q  <= curr_addr_d;
            start_q      <= start_d;
            pend_addr_q  <= pend_addr_d;
            bytes_left_q <= bytes_left_d;
            size_q       <= size_d;
            pend_size_q  <= pend_size_d;
            cont_q       <= cont_d;
            pend_cont_q  <= pend_cont_d;
            pending_q    <= pending_d;
            dsize_q      <= dsize_d;
            data_q       <= data_d;
`ifdef UDMA_TX_RESP_STALL_EN
            req_seen_q   <= req_seen_d;
            stall_cnt_q  <= stall_cnt_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        curr_addr_d  = curr_addr_q;
        start_d      = start_q;
        pend_addr_d  = pend_addr_q;
        bytes_left_d = bytes_left_q;
        size_d       = size_q;
        pend_size_d  = pend_size_q;
        cont_d       = cont_q;
        pend_cont_d  = pend_cont_q;
        pending_d    = pending_q;
        dsize_d      = dsize_q;
        data_d       = data_q;
`ifdef UDMA_TX_RESP_STALL_EN
        req_seen_d   = req_seen_q;
        stall_cnt_d  = stall_cnt_q;
`endif

        case (state_q)
            ST_WAIT_REQ: begin
`ifdef UDMA_TX_RESP_STALL_EN
                // Counter holds the remaining stall cycles minus one
                if (req_seen_q) begin
                    if (stall_cnt_q == 4'd0) begin
                        req_seen_d = 1'b0;
                        state_d    = ST_GRANT;
                    end else begin
                        stall_cnt_d = stall_cnt_q - 4'd1;
                    end
                end else if (req_i) begin
                    dsize_d = datasize_i;
                    if (stall_cycles_i == 4'd0) begin
                        state_d = ST_GRANT;
                    end else begin
                        req_seen_d  = 1'b1;
                        stall_cnt_d = stall_cycles_i - 4'd1;
                    end
                end
`else
                if (req_i) begin
                    dsize_d = datasize_i;
                    state_d = ST_GRANT;
                end
`endif
            end
            ST_GRANT: begin
                data_d  = w_rd_data;
                state_d = ST_DATA;
            end
            ST_DATA: begin
                if (ready_i) begin
                    curr_addr_d  = w_next_addr;
                    bytes_left_d = w_next_left;
                    state_d      = ST_WAIT_REQ;
                    if (w_next_left == '0) begin
                        if (cont_q) begin
                            curr_addr_d  = start_q;
                            bytes_left_d = size_q;
                        end else if (pending_q) begin
                            curr_addr_d  = pend_addr_q;
                            bytes_left_d = pend_size_q;
                            start_d      = pend_addr_q;
                            size_d       = pend_size_q;
                            cont_d       = pend_cont_q;
                            pending_d    = 1'b0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            default: ;
        endcase

        // Configuration requests act on top of the beat result. Checking
        // state_d lets a start pulse that coincides with the final beat
        // launch directly instead of leaving an orphaned queue entry.
        if (cfg_clr_i) begin
            state_d   = ST_IDLE;
            pending_d = 1'b0;
`ifdef UDMA_TX_RESP_STALL_EN
            req_seen_d = 1'b0;
`endif
        end else if (cfg_en_i && (cfg_size_i != '0)) begin
            if (state_d == ST_IDLE) begin
                curr_addr_d  = cfg_startaddr_i;
                bytes_left_d = cfg_size_i;
                start_d      = cfg_startaddr_i;
                size_d       = cfg_size_i;
                cont_d       = cfg_continuous_i;
                state_d      = ST_WAIT_REQ;
            end else begin
                pend_addr_d = cfg_startaddr_i;
                pend_size_d = cfg_size_i;
                pend_cont_d = cfg_continuous_i;
                pending_d   = 1'b1;
            end
        end
    end

    // Outputs
    always_comb begin
        cfg_en_o         = (state_q != ST_IDLE);
        gnt_o            = (state_q == ST_GRANT);
        valid_o          = (state_q == ST_DATA);
        cfg_pending_o    = pending_q;
        cfg_curr_addr_o  = curr_addr_q;
        cfg_bytes_left_o = bytes_left_q;
        data_o           = data_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_udma_tx_chan_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_udma_tx_chan_resp
// Purpose  : Self-checking bench for udma_tx_chan_resp. A beat table drives
//            most transfers; hand-written sequences cover abort, queueing,
//            ignored starts/requests, reset mid-beat and the stall option.
//            Expected beat data goes into a scoreboard queue and is popped
//            when the DUT completes a beat.
// Revision : 1.0 - initial release
// ============================================================================
module tb_udma_tx_chan_resp;

    logic        sys_clk_i;
    logic        rstn_i;
    logic [11:0] cfg_startaddr_i;
    logic [15:0] cfg_size_i;
    logic        cfg_continuous_i;
    logic        cfg_en_i;
    logic        cfg_clr_i;
    logic        cfg_en_o;
    logic        cfg_pending_o;
    logic [11:0] cfg_curr_addr_o;
    logic [15:0] cfg_bytes_left_o;
    logic        req_i;
    logic        gnt_o;
    logic [1:0]  datasize_i;
    logic [31:0] data_o;
    logic        valid_o;
    logic        ready_i;
    logic        mem_we_i;
    logic [7:0]  mem_waddr_i;
    logic [31:0] mem_wdata_i;
`ifdef UDMA_TX_RESP_STALL_EN
    logic [3:0]  stall_cycles_i;
`endif

    udma_tx_chan_resp #(
        .L2_AWIDTH_NOAL (12),
        .TRANS_SIZE     (16),
        .MEM_AWIDTH     (8)
    ) dut (
        .sys_clk_i        (sys_clk_i),
        .rstn_i           (rstn_i),
        .cfg_startaddr_i  (cfg_startaddr_i),
        .cfg_size_i       (cfg_size_i),
        .cfg_continuous_i (cfg_continuous_i),
        .cfg_en_i         (cfg_en_i),
        .cfg_clr_i        (cfg_clr_i),
        .cfg_en_o         (cfg_en_o),
        .cfg_pending_o    (cfg_pending_o),
        .cfg_curr_addr_o  (cfg_curr_addr_o),
        .cfg_bytes_left_o (cfg_bytes_left_o),
        .req_i            (req_i),
        .gnt_o            (gnt_o),
        .datasize_i       (datasize_i),
`ifdef UDMA_TX_RESP_STALL_EN
        .stall_cycles_i   (stall_cycles_i),
`endif
        .data_o           (data_o),
        .valid_o          (valid_o),
        .ready_i          (ready_i),
        .mem_we_i         (mem_we_i),
        .mem_waddr_i      (mem_waddr_i),
        .mem_wdata_i      (mem_wdata_i)
    );

    initial sys_clk_i = 1'b0;
    always #5 sys_clk_i = ~sys_clk_i;

    typedef struct {
        bit          do_start;
        logic [11:0] start;
        logic [15:0] size;
        bit          cont;
        logic [1:0]  ds;
        int          hold;
        logic [31:0] exp_data;
        logic [11:0] exp_addr;
        logic [15:0] exp_left;
        bit          exp_en;
    } beat_t;

    localparam int N_ROWS = 13;
    beat_t tbl [N_ROWS];

    int          n_checks = 0;
    int          n_fail   = 0;
    int          exp_lat  = 1;
    logic [31:0] sb_q [$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard consumer: one expected word per completed beat
    always @(negedge sys_clk_i) begin
        if (rstn_i && valid_o && ready_i) begin
            if (sb_q.size() == 0) begin
                check("unexpected_beat", data_o, 32'hFFFF_FFFF);
            end else begin
                check("beat_data", data_o, sb_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge sys_clk_i);
        #1;
    endtask

    task automatic mem_write(input logic [7:0] a, input logic [31:0] d);
        mem_we_i = 1'b1; mem_waddr_i = a; mem_wdata_i = d;
        tick();
        mem_we_i = 1'b0;
    endtask

    task automatic start_xfer(input logic [11:0] a, input logic [15:0] s,
                              input bit c);
        cfg_startaddr_i = a; cfg_size_i = s; cfg_continuous_i = c;
        cfg_en_i = 1'b1;
        tick();
        cfg_en_i = 1'b0;
    endtask

    task automatic run_beat(input logic [1:0] ds, input int hold,
                            input logic [31:0] exp_data);
        int lat;
        sb_q.push_back(exp_data);
        req_i = 1'b1; datasize_i = ds; lat = 0;
        do begin
            tick();
            req_i = 1'b0;
            lat++;
        end while (!gnt_o && lat < 20);
        check("gnt_latency", lat, exp_lat);
        check("gnt_seen", gnt_o, 1);
        tick();
        check("gnt_pulse", gnt_o, 0);
        check("valid_up", valid_o, 1);
        check("data_first", data_o, exp_data);
        for (int h = 0; h < hold; h++) begin
            tick();
            check("valid_held", valid_o, 1);
            check("data_held", data_o, exp_data);
        end
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
    endtask

    task automatic expect_no_gnt(input int cycles);
        req_i = 1'b1;
        for (int k = 0; k < cycles; k++) begin
            tick();
            check("no_gnt", gnt_o, 0);
        end
        req_i = 1'b0;
    endtask

    initial begin
        //            start  addr    size   cont ds hold data          addr    left   en
        tbl[0]  = '{1'b1, 12'h000, 16'd4, 1'b0, 2'd0, 0, 32'h0000_0011, 12'h001, 16'd3, 1'b1};
        tbl[1]  = '{1'b0, 12'h000, 16'd0, 1'b0, 2'd0, 0, 32'h0000_0022, 12'h002, 16'd2, 1'b1};
        tbl[2]  = '{1'b0, 12'h000, 16'd0, 1'b0, 2'd0, 0, 32'h0000_0033, 12'h003, 16'd1, 1'b1};
        tbl[3]  = '{1'b0, 12'h000, 16'd0, 1'b0, 2'd0, 1, 32'h0000_0044, 12'h004, 16'd0, 1'b0};
        tbl[4]  = '{1'b1, 12'h002, 16'd2, 1'b0, 2'd1, 3, 32'h0000_4433, 12'h004, 16'd0, 1'b0};
        tbl[5]  = '{1'b1, 12'h004, 16'd6, 1'b0, 2'd2, 0, 32'h8877_6655, 12'h008, 16'd2, 1'b1};
        tbl[6]  = '{1'b0, 12'h000, 16'd0, 1'b0, 2'd1, 2, 32'h0000_AA99, 12'h00A, 16'd0, 1'b0};
        tbl[7]  = '{1'b1, 12'h005, 16'd3, 1'b0, 2'd1, 0, 32'h0000_7766, 12'h007, 16'd1, 1'b1};
        tbl[8]  = '{1'b0, 12'h000, 16'd0, 1'b0, 2'd1, 0, 32'h0000_0088, 12'h009, 16'd0, 1'b0};
        tbl[9]  = '{1'b1, 12'hFFE, 16'd4, 1'b0, 2'd1, 0, 32'h0000_DEAD, 12'h000, 16'd2, 1'b1};
        tbl[10] = '{1'b0, 12'h000, 16'd0, 1'b0, 2'd1, 0, 32'h0000_2211, 12'h002, 16'd0, 1'b0};
        tbl[11] = '{1'b1, 12'h000, 16'd4, 1'b1, 2'd2, 0, 32'h4433_2211, 12'h000, 16'd4, 1'b1};
        tbl[12] = '{1'b0, 12'h000, 16'd0, 1'b0, 2'd2, 1, 32'h4433_2211, 12'h000, 16'd4, 1'b1};

        rstn_i = 1'b0; cfg_startaddr_i = '0; cfg_size_i = '0;
        cfg_continuous_i = 1'b0; cfg_en_i = 1'b0; cfg_clr_i = 1'b0;
        req_i = 1'b0; datasize_i = 2'd0; ready_i = 1'b0;
        mem_we_i = 1'b0; mem_waddr_i = '0; mem_wdata_i = '0;
`ifdef UDMA_TX_RESP_STALL_EN
        stall_cycles_i = 4'd0;
`endif
        tick(); tick();
        check("rst_en", cfg_en_o, 0);
        check("rst_pending", cfg_pending_o, 0);
        check("rst_addr", cfg_curr_addr_o, 0);
        check("rst_left", cfg_bytes_left_o, 0);
        check("rst_gnt", gnt_o, 0);
        check("rst_valid", valid_o, 0);
        check("rst_data", data_o, 0);
        rstn_i = 1'b1;
        tick();

        mem_write(8'h00, 32'h4433_2211);
        mem_write(8'h01, 32'h8877_6655);
        mem_write(8'h02, 32'hCCBB_AA99);
        mem_write(8'hFF, 32'hDEAD_BEEF);

        // Table-driven beats
        for (int r = 0; r < N_ROWS; r++) begin
            if (tbl[r].do_start) begin
                start_xfer(tbl[r].start, tbl[r].size, tbl[r].cont);
                check("start_en", cfg_en_o, 1);
                check("start_addr", cfg_curr_addr_o, tbl[r].start);
                check("start_left", cfg_bytes_left_o, tbl[r].size);
            end
            run_beat(tbl[r].ds, tbl[r].hold, tbl[r].exp_data);
            check("row_addr", cfg_curr_addr_o, tbl[r].exp_addr);
            check("row_left", cfg_bytes_left_o, tbl[r].exp_left);
            check("row_en", cfg_en_o, tbl[r].exp_en);
        end

        // Abort while valid_o is high (continuous transfer still running);
        // a simultaneous start pulse must lose to the abort.
        req_i = 1'b1; datasize_i = 2'd2;
        for (int k = 0; k < 20 && !gnt_o; k++) begin
            tick();
            req_i = 1'b0;
        end
        req_i = 1'b0;
        tick();
        check("clr_pre_valid", valid_o, 1);
        cfg_clr_i = 1'b1; cfg_en_i = 1'b1; cfg_size_i = 16'd4;
        tick();
        cfg_clr_i = 1'b0; cfg_en_i = 1'b0;
        check("clr_valid", valid_o, 0);
        check("clr_en", cfg_en_o, 0);
        check("clr_pending", cfg_pending_o, 0);
        expect_no_gnt(3);

        // Zero-size start is ignored; requests in IDLE are ignored
        start_xfer(12'h000, 16'd0, 1'b0);
        check("size0_en", cfg_en_o, 0);
        expect_no_gnt(2);

        // Queued transfer, second start overwrites the queue
        start_xfer(12'h000, 16'd2, 1'b0);
        start_xfer(12'h004, 16'd1, 1'b0);
        check("queue_pending", cfg_pending_o, 1);
        start_xfer(12'h008, 16'd1, 1'b0);
        check("queue_pending2", cfg_pending_o, 1);
        run_beat(2'd0, 0, 32'h0000_0011);
        check("q_left1", cfg_bytes_left_o, 1);
        check("q_pend1", cfg_pending_o, 1);
        run_beat(2'd0, 0, 32'h0000_0022);
        check("q_load_addr", cfg_curr_addr_o, 12'h008);
        check("q_load_left", cfg_bytes_left_o, 1);
        check("q_load_en", cfg_en_o, 1);
        check("q_cleared", cfg_pending_o, 0);
        run_beat(2'd0, 0, 32'h0000_0099);
        check("q_done_en", cfg_en_o, 0);

`ifdef UDMA_TX_RESP_STALL_EN
        stall_cycles_i = 4'd3;
        exp_lat = 4;
        start_xfer(12'h000, 16'd1, 1'b0);
        run_beat(2'd0, 0, 32'h0000_0011);
        check("stall_done_en", cfg_en_o, 0);
        stall_cycles_i = 4'd0;
        exp_lat = 1;
`endif

        // Asynchronous reset while a beat is valid
        start_xfer(12'h000, 16'd4, 1'b0);
        req_i = 1'b1; datasize_i = 2'd0;
        for (int k = 0; k < 20 && !gnt_o; k++) begin
            tick();
            req_i = 1'b0;
        end
        req_i = 1'b0;
        tick();
        check("rst_pre_valid", valid_o, 1);
        rstn_i = 1'b0;
        #1;
        check("arst_valid", valid_o, 0);
        check("arst_en", cfg_en_o, 0);
        check("arst_addr", cfg_curr_addr_o, 0);
        check("arst_left", cfg_bytes_left_o, 0);
        tick();
        rstn_i = 1'b1;
        tick();
        expect_no_gnt(3);
        check("arst_no_valid", valid_o, 0);

        check("scoreboard_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
